// File: rtl/ahb_decoder24.sv
// AHB-Lite address decoder and default slave for a 24-slave interconnect.
// Optional error log (err_flag/err_addr) is built only when AHB_DEC_ERRLOG_EN is defined.
module ahb_decoder24 #(
    parameter int          AW        = 32,
    parameter int          SLV_SHIFT = 16,
    parameter logic [AW-1:0] BASE_HI = '0
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hready,
    output logic [23:0]   hsel,
    output logic          hsel_def,
    output logic [23:0]   hsel_d,
    output logic          hsel_def_d,
    output logic          hreadyout_def,
    output logic          hresp_def,
    output logic          err_flag,
    output logic [AW-1:0] err_addr,
    input  logic          err_clr
);

    localparam int HI_W = AW - SLV_SHIFT - 5;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_ERR1 = 2'd1,
        D_ERR2 = 2'd2
    } dstate_e;

    logic [4:0] idx;
    logic       hit;
    logic       start;

    dstate_e    state_q;
    logic [23:0] hsel_dp_q;
    logic       hsel_def_dp_q;
    logic       hreadyout_q;
    logic       hresp_q;

    // NOTE: every output of an always_comb gets a default first, otherwise a path
    // that skips the assignment infers a latch.
    always_comb begin
        hsel = '0;
        idx  = haddr[SLV_SHIFT+4:SLV_SHIFT];
        hit  = (haddr[AW-1:SLV_SHIFT+5] == BASE_HI[HI_W-1:0]) && (idx < 5'd24);
        for (int i = 0; i < 24; i++) begin
            hsel[i] = hit && (idx == 5'(i));
        end
    end

    assign hsel_def = ~hit;
    assign start    = hsel_def & hready & htrans[1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            hsel_dp_q     <= '0;
            hsel_def_dp_q <= 1'b1;
            state_q       <= D_IDLE;
            hreadyout_q   <= 1'b1;
            hresp_q       <= 1'b0;
        end else begin
            if (hready) begin
                hsel_dp_q     <= hsel;
                hsel_def_dp_q <= hsel_def;
            end
            // Outputs are registered with the state they belong to.
            case (state_q)
                D_ERR1: begin
                    state_q     <= D_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                D_IDLE, D_ERR2: begin
                    if (start) begin
                        state_q     <= D_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= 1'b1;
                    end else begin
                        state_q     <= D_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= D_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
            endcase
        end
    end

    assign hsel_d        = hsel_dp_q;
    assign hsel_def_d    = hsel_def_dp_q;
    assign hreadyout_def = hreadyout_q;
    assign hresp_def     = hresp_q;

`ifdef AHB_DEC_ERRLOG_EN
    logic          err_flag_q;
    logic [AW-1:0] err_addr_q;
    logic          unused_ok;

    // Only the first unmapped access is logged; a clear wins over a same-cycle start.
    always_ff @(posedge hclk) begin
        if (!hresetn || err_clr) begin
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else if (start && !err_flag_q) begin
            err_flag_q <= 1'b1;
            err_addr_q <= haddr;
        end
    end

    assign err_flag  = err_flag_q;
    assign err_addr  = err_addr_q;
    assign unused_ok = htrans[0];
`else
    logic unused_ok;

    assign err_flag  = 1'b0;
    assign err_addr  = '0;
    assign unused_ok = ^{err_clr, htrans[0], haddr[SLV_SHIFT-1:0]};
`endif

endmodule

// File: tb/tb_ahb_decoder24.sv
// Self-checking bench for ahb_decoder24: directed plan steps followed by random
// traffic, all checked against a cycle-level behavioural model of the decoder.
module tb_ahb_decoder24;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic [23:0] hsel;
    logic        hsel_def;
    logic [23:0] hsel_d;
    logic        hsel_def_d;
    logic        hreadyout_def;
    logic        hresp_def;
    logic        err_flag;
    logic [31:0] err_addr;
    logic        err_clr;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [23:0] m_hsel_d;
    logic        m_def_d;
    int          m_err_left;    // 2: first ERROR cycle, 1: second ERROR cycle, 0: OKAY
    logic        m_flag;
    logic [31:0] m_eaddr;

    ahb_decoder24 dut (
        .hclk          (hclk),
        .hresetn       (hresetn),
        .haddr         (haddr),
        .htrans        (htrans),
        .hready        (hready),
        .hsel          (hsel),
        .hsel_def      (hsel_def),
        .hsel_d        (hsel_d),
        .hsel_def_d    (hsel_def_d),
        .hreadyout_def (hreadyout_def),
        .hresp_def     (hresp_def),
        .err_flag      (err_flag),
        .err_addr      (err_addr),
        .err_clr       (err_clr)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mapped(input logic [31:0] a);
        return ((a / 32'h0020_0000) == 0) && (((a / 32'h0001_0000) % 32) < 24);
    endfunction

    function automatic logic [23:0] exp_sel(input logic [31:0] a);
        if (is_mapped(a)) return 24'(1 << ((a / 32'h0001_0000) % 32));
        return 24'h0;
    endfunction

    // One bus cycle: drive at negedge, check decode, clock, then check registered outputs.
    task automatic step(input logic rst_n, input logic [31:0] a, input logic [1:0] tr,
                        input logic rdy, input logic clr);
        bit start;
        @(negedge hclk);
        hresetn = rst_n;
        haddr   = a;
        htrans  = tr;
        hready  = rdy;
        err_clr = clr;
        #1;
        chk("hsel", 32'(hsel), 32'(exp_sel(a)));
        chk("hsel_def", 32'(hsel_def), 32'(!is_mapped(a)));
        start = !is_mapped(a) && rdy && tr[1];
        @(posedge hclk);
        if (!rst_n) begin
            m_hsel_d   = '0;
            m_def_d    = 1'b1;
            m_err_left = 0;
            m_flag     = 1'b0;
            m_eaddr    = '0;
        end else begin
            if (rdy) begin
                m_hsel_d = exp_sel(a);
                m_def_d  = !is_mapped(a);
            end
            if (m_err_left == 2) m_err_left = 1;
            else                 m_err_left = start ? 2 : 0;
            if (clr) begin
                m_flag  = 1'b0;
                m_eaddr = '0;
            end else if (start && !m_flag) begin
                m_flag  = 1'b1;
                m_eaddr = a;
            end
        end
        #1;
        chk("hsel_d", 32'(hsel_d), 32'(m_hsel_d));
        chk("hsel_def_d", 32'(hsel_def_d), 32'(m_def_d));
        chk("hreadyout_def", 32'(hreadyout_def), 32'(m_err_left != 2));
        chk("hresp_def", 32'(hresp_def), 32'(m_err_left != 0));
`ifdef AHB_DEC_ERRLOG_EN
        chk("err_flag", 32'(err_flag), 32'(m_flag));
        chk("err_addr", err_addr, m_eaddr);
`else
        chk("err_flag", 32'(err_flag), 32'h0);
        chk("err_addr", err_addr, 32'h0);
`endif
    endtask

    initial begin
        logic [31:0] a;
        hresetn = 1'b0; haddr = '0; htrans = 2'b00; hready = 1'b1; err_clr = 1'b0;
        m_hsel_d = '0; m_def_d = 1'b1; m_err_left = 0; m_flag = 1'b0; m_eaddr = '0;

        // Reset for two cycles
        step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
        step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0);
        chk("reset_hsel_d", 32'(hsel_d), 32'h0);
        chk("reset_hsel_def_d", 32'(hsel_def_d), 32'h1);

        // Mapped NONSEQ to slave 5
        step(1'b1, 32'h0005_0010, 2'b10, 1'b1, 1'b0);
        chk("plan_hsel_d_slv5", 32'(hsel_d), 32'h0000_0020);
        chk("plan_okay_after_mapped", 32'(hresp_def), 32'h0);

        // Unmapped idx 24: ERROR pair then OKAY
        step(1'b1, 32'h0018_0000, 2'b10, 1'b1, 1'b0);
        chk("plan_err1_ready", 32'(hreadyout_def), 32'h0);
        step(1'b1, 32'h0018_0000, 2'b00, 1'b0, 1'b0);
        chk("plan_err2_resp", 32'(hresp_def), 32'h1);
        step(1'b1, 32'h0000_0000, 2'b00, 1'b1, 1'b0);
        chk("plan_okay_resp", 32'(hresp_def), 32'h0);

        // Upper-bit mismatch, then mapped NONSEQ accepted in D_ERR2
        step(1'b1, 32'h0100_0000, 2'b10, 1'b1, 1'b0);
        step(1'b1, 32'h0100_0000, 2'b10, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0000, 2'b10, 1'b1, 1'b0);
        chk("plan_slv0_after_err", 32'(hsel_d), 32'h0000_0001);

        // IDLE to unmapped gives OKAY; hready low holds data-phase selects
        step(1'b1, 32'h00FF_0000, 2'b00, 1'b1, 1'b0);
        chk("plan_idle_okay", 32'(hresp_def), 32'h0);
        step(1'b1, 32'h0003_0000, 2'b10, 1'b0, 1'b0);
        step(1'b1, 32'h001F_0000, 2'b11, 1'b0, 1'b0);
        step(1'b1, 32'h0007_0000, 2'b10, 1'b0, 1'b0);
        chk("plan_hold_def_d", 32'(hsel_def_d), 32'h1);

        // Error log: two unmapped accesses, only first logged, then clear
        step(1'b1, 32'h0019_0000, 2'b10, 1'b1, 1'b0);
        step(1'b1, 32'h0019_0000, 2'b10, 1'b0, 1'b0);
        step(1'b1, 32'h001A_0000, 2'b10, 1'b1, 1'b0);
        step(1'b1, 32'h001A_0000, 2'b10, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0000, 2'b00, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0000, 2'b00, 1'b1, 1'b1);
        // Clear wins over a simultaneous start
        step(1'b1, 32'h001B_0000, 2'b10, 1'b1, 1'b1);
        // Reset asserted in D_ERR1
        step(1'b1, 32'h001C_0000, 2'b10, 1'b1, 1'b0);
        step(1'b0, 32'h001C_0000, 2'b10, 1'b0, 1'b0);
        chk("plan_reset_in_err1", 32'(hresp_def), 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            a = {($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'h0,
                 5'($urandom_range(0, 31)), 16'($urandom)};
            step(($urandom_range(0, 49) != 0), a, 2'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
